// File: rtl/spike_synapse.sv
// Synapse front end: delays signed spike events, weights them into an
// 8-bit synaptic current that decays geometrically on a fixed tick.
module spike_synapse #(
   parameter int WIDTH        = 8,
   parameter int WEIGHT_INIT  = 16,
   parameter int DECAY_SHIFT  = 2,
   parameter int DECAY_PERIOD = 4,
   parameter int DELAY        = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             spike_in,
   input  logic             inhibit_in,
   input  logic [WIDTH-1:0] weight_in,
   input  logic             weight_load,
   output logic [WIDTH-1:0] current,
   output logic [WIDTH-1:0] weight,
   output logic [7:0]       spike_count,
   output logic             active
);

   localparam int               TW         = $clog2(DECAY_PERIOD);
   localparam logic [TW-1:0]    TIMER_LAST = TW'(DECAY_PERIOD - 1);
   localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
   localparam logic [WIDTH-1:0] CUR_MAX    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CUR_ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] W_INIT     = WIDTH'(WEIGHT_INIT);

   logic [WIDTH-1:0] current_q, current_d;
   logic [WIDTH-1:0] weight_q, weight_d;
   logic [7:0]       count_q, count_d;
   logic             active_q, active_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [DELAY-1:0] spk_q, spk_d;
   logic [DELAY-1:0] inh_q, inh_d;

   logic             tick_s;
   logic             deliver_s;
   logic             deliver_inh_s;
   logic [WIDTH-1:0] dec_s;
   logic [WIDTH-1:0] base_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] next_cur_s;
   logic [DELAY:0]   spk_ext_s;
   logic [DELAY:0]   inh_ext_s;

   // Next-state logic: decay first, then the delivered spike term.
   always_comb begin
      current_d     = current_q;
      weight_d      = weight_q;
      count_d       = count_q;
      active_d      = active_q;
      timer_d       = timer_q;
      spk_d         = spk_q;
      inh_d         = inh_q;
      spk_ext_s     = {spk_q, spike_in};
      inh_ext_s     = {inh_q, inhibit_in};
      deliver_s     = spk_q[DELAY-1];
      deliver_inh_s = inh_q[DELAY-1];
      tick_s        = (timer_q == TIMER_LAST);
      dec_s         = current_q >> DECAY_SHIFT;

      // A shift that rounds to zero still removes one so decay always ends at 0.
      if (tick_s) begin
         if ((current_q != '0) && (dec_s == '0)) begin
            base_s = current_q - CUR_ONE;
         end else begin
            base_s = current_q - dec_s;
         end
      end else begin
         base_s = current_q;
      end

      sum_s = {1'b0, base_s} + {1'b0, weight_q};

      if (deliver_s && !deliver_inh_s) begin
         next_cur_s = sum_s[WIDTH] ? CUR_MAX : sum_s[WIDTH-1:0];
      end else if (deliver_s && deliver_inh_s) begin
         next_cur_s = (base_s < weight_q) ? '0 : (base_s - weight_q);
      end else begin
         next_cur_s = base_s;
      end

      if (ena) begin
         current_d = next_cur_s;
         active_d  = (next_cur_s != '0);
         weight_d  = weight_load ? weight_in : weight_q;
         timer_d   = tick_s ? '0 : (timer_q + TIMER_ONE);
         spk_d     = spk_ext_s[DELAY-1:0];
         inh_d     = inh_ext_s[DELAY-1:0];
         if (deliver_s && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
         end else begin
            count_d = count_q;
         end
      end else begin
         current_d = current_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current_q <= '0;
         weight_q  <= W_INIT;
         count_q   <= 8'd0;
         active_q  <= 1'b0;
         timer_q   <= '0;
         spk_q     <= '0;
         inh_q     <= '0;
      end else begin
         current_q <= current_d;
         weight_q  <= weight_d;
         count_q   <= count_d;
         active_q  <= active_d;
         timer_q   <= timer_d;
         spk_q     <= spk_d;
         inh_q     <= inh_d;
      end
   end

   assign current     = current_q;
   assign weight      = weight_q;
   assign spike_count = count_q;
   assign active      = active_q;

endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
Synapse front end for the LIF neuron. It converts incoming spike events into the 8-bit synaptic current that drives the neuron's current input, performing the reverse of the neuron's current-to-spike conversion. Each delivered spike adds or subtracts a programmable weight, after a configurable axonal delay. The accumulated current decays geometrically on a fixed tick. The block sits between a spike source (another neuron's spike output or a pin) and the neuron's current input.

Parameters:
WIDTH, 8, bit width of current and weight datapath
WEIGHT_INIT, 16, weight register value after reset
DECAY_SHIFT, 2, decay per tick is current >> DECAY_SHIFT (range 1..WIDTH-1)
DECAY_PERIOD, 4, enabled cycles between decay ticks (>=2)
DELAY, 2, axonal delay stages (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; low freezes all state
spike_in  in  1  incoming spike, sampled each enabled rising edge
inhibit_in  in  1  sign of the spike sampled with it (1 = inhibitory)
weight_in  in  WIDTH  new weight value
weight_load  in  1  load weight_in into the weight register
current  out  WIDTH  synaptic current, registered
weight  out  WIDTH  current weight register
spike_count  out  8  count of delivered spikes, saturating
active  out  1  registered; high when current != 0

Behaviour:
- Reset (async, rst_n=0): current=0, weight=WEIGHT_INIT, spike_count=0, active=0, decay timer=0, all delay stages cleared (spike and sign bits).
- Delay line: DELAY-stage shift register of {spike_in, inhibit_in}, shifting on each enabled edge.
  - Delivered spike = last stage.
  - A spike sampled at enabled edge k updates current at enabled edge k+DELAY.
  - Back-to-back spikes are all delivered; none are merged.
- Decay timer: counts 0..DECAY_PERIOD-1, incrementing each enabled edge. A tick occurs on the edge where timer == DECAY_PERIOD-1; the timer then wraps to 0. With the defaults, the first tick after reset is on the 4th enabled edge.
- Current update per enabled edge:
  - base = current if no tick.
  - On a tick: base = current - (current >> DECAY_SHIFT). If current != 0 and (current >> DECAY_SHIFT) == 0, base = current - 1, which guarantees decay reaches 0.
  - With no delivered spike: current <= base.
  - Delivered excitatory spike: current <= min(base + weight, 2^WIDTH-1). Compute the sum with 1 extra bit.
  - Delivered inhibitory spike: current <= max(base - weight, 0).
  - Decay is applied before the spike term when both occur on the same edge.
- Weight: weight_load=1 on an enabled edge sets weight <= weight_in. A spike delivered on that same edge uses the old weight.
- spike_count increments on every delivered spike, either sign, and saturates at 255.
- active <= (next current != 0), so it is registered alongside current.
- ena=0: all registers hold. spike_in, inhibit_in and weight_load are ignored and lost.
- Reset mid-operation clears in-flight spikes, so nothing is delivered after release. The first enabled edge after release is timer edge 1.

Test Plan:
1. Reset check: assert rst_n=0 asynchronously mid-cycle -> immediately current=0, weight=16, spike_count=0, active=0.
2. Single spike decay (defaults):
   - Stimulus: excitatory spike on enabled edge 1.
   - Edges 2-3: current=0 at edge 2, 16 at edge 3, active=1.
   - Decay ticks: 12 at edge 4, 9 at edge 8, 7 at edge 12.
   - Continued ticks: 6, 5, 4, 3, 2, 1, 0. active=0 on the edge current reaches 0.
3. Saturation and coincident tick:
   - weight_load weight_in=200, then spikes at edges 2 and 3 (delivered at edges 4 and 5).
   - Edge 4 is a tick with base 0 -> current=200.
   - Edge 5 -> 255, clamped.
   - spike_count=2.
4. Inhibit clamp and weight hazard:
   - Stimulus: current=16; weight_load=1 with weight_in=40 on the same edge an inhibitory spike is delivered.
   - Result: 16-16=0 using the old weight, then weight=40.
   - Next inhibitory spike with current=0 -> current stays 0, no underflow.
5. Enable freeze: hold ena=0 for 10 cycles with spike_in=1 and current=12 -> current, timer, delay line and count unchanged; no spike delivered after ena returns.
6. Count saturation: deliver 300 spikes with weight=0 -> spike_count sticks at 255; current stays 0.
